snake_game_ctrl: RTL and testbench

- Game-level sequencer for the `snake` body-memory datapath.
- Paces the game with a tick divider and latches player direction with reversal filtering.
- Issues one `shift` per tick, waits for `end_shift`, then checks the new head against the food cell and grows the snake.
- Ends the game on self-collision or full board; sits between the button/debounce logic and `snake`/VGA overlay.

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_lfsr16.sv | 25 ++
 rtl/snake_game_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller: directions, FSM states,
// the width helper and the food LFSR step function.
package snake_pkg;

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_UP    = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_INIT    = 4'd1,
      ST_WAIT    = 4'd2,
      ST_SHIFT   = 4'd3,
      ST_SCAN    = 4'd4,
      ST_SETTLE0 = 4'd5,
      ST_SETTLE1 = 4'd6,
      ST_CHECK   = 4'd7,
      ST_OVER    = 4'd8
   } state_t;

   // Bits needed to index n values (ceil(log2(n)), minimum 0).
   function automatic int logb2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Fibonacci LFSR with taps 16,14,13,11.
   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running seeded 16-bit LFSR used to place food.
module snake_lfsr16
   import snake_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] value
);

   logic [15:0] lfsr_r;

   // Advance once per clock in every game state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_r <= SEED;
      end else begin
         lfsr_r <= lfsr16_next(lfsr_r);
      end
   end

   assign value = lfsr_r;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-level sequencer for the snake body datapath: tick pacing, direction
// filtering, shift/scan handshake, food/growth and end-of-game detection.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int          H         = 32,
   parameter int          V         = 32,
   parameter int          TICK_DIV  = 5000000,
   parameter int          INIT_LEN  = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         XB        = logb2(H),
   localparam int         YB        = logb2(V),
   localparam int         AB        = logb2(H * V)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic               btn_valid,
   input  logic [1:0]         btn_dir,
   input  logic               end_shift,
   input  logic               self_col,
   input  logic [XB+YB:0]     last_head,
   output logic               snake_rst,
   output logic               shift,
   output logic [1:0]         move,
   output logic [AB-1:0]      length,
   output logic [XB-1:0]      food_x,
   output logic [YB-1:0]      food_y,
   output logic [AB-1:0]      score,
   output logic               game_over,
   output logic               win
);

   localparam int            TW        = logb2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [AB-1:0] LEN_INIT  = AB'(INIT_LEN);
   localparam logic [AB-1:0] LEN_MAX   = AB'(H * V - 1);
   localparam logic [XB-1:0] FOOD_X0   = XB'(H / 4);
   localparam logic [YB-1:0] FOOD_Y0   = YB'(V / 4);

   state_t          state_r, next_state_s;
   logic [TW-1:0]   tick_cnt_r, tick_cnt_nx;
   logic [1:0]      pending_r, pending_nx;
   logic [1:0]      move_nx, rev_dir_s;
   logic [AB-1:0]   length_nx, score_nx, len_inc_s;
   logic [XB-1:0]   food_x_nx, rnd_x_s;
   logic [YB-1:0]   food_y_nx, rnd_y_s;
   logic            win_nx, snake_rst_nx, shift_nx, game_over_nx;
   logic            tick_done_s, head_hit_s, btn_accept_s, running_s;
   logic [15:0]     lfsr_s;
   logic            unused_s;

   snake_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .value (lfsr_s)
   );

   assign rnd_x_s      = lfsr_s[XB-1:0];
   assign rnd_y_s      = lfsr_s[8+YB-1:8];
   assign unused_s     = ^{lfsr_s[15:8+YB], lfsr_s[7:XB], last_head[0]};
   assign tick_done_s  = (tick_cnt_r == TICK_LAST) && !pause;
   assign head_hit_s   = (last_head[XB+YB:1] == {food_x, food_y});
   assign len_inc_s    = length + AB'(1);
   assign rev_dir_s    = move + 2'd2;
   assign running_s    = (state_r != ST_IDLE) && (state_r != ST_OVER);
   assign btn_accept_s = btn_valid && running_s && (btn_dir != rev_dir_s);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE:    next_state_s = start ? ST_INIT : ST_IDLE;
         ST_INIT:    next_state_s = ST_WAIT;
         ST_WAIT:    next_state_s = tick_done_s ? ST_SHIFT : ST_WAIT;
         ST_SHIFT:   next_state_s = ST_SCAN;
         ST_SCAN:    next_state_s = end_shift ? ST_SETTLE0 : ST_SCAN;
         ST_SETTLE0: next_state_s = ST_SETTLE1;
         ST_SETTLE1: next_state_s = ST_CHECK;
         ST_CHECK: begin
            if (self_col) begin
               next_state_s = ST_OVER;
            end else if (head_hit_s && (len_inc_s == LEN_MAX)) begin
               next_state_s = ST_OVER;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_OVER:    next_state_s = start ? ST_INIT : ST_OVER;
         default:    next_state_s = ST_IDLE;
      endcase
   end

   // Output and datapath next values; pulses are registered off the next state.
   always_comb begin
      snake_rst_nx = (next_state_s == ST_INIT);
      shift_nx     = (next_state_s == ST_SHIFT);
      game_over_nx = (next_state_s == ST_OVER);
      tick_cnt_nx  = tick_cnt_r;
      move_nx      = move;
      length_nx    = length;
      score_nx     = score;
      food_x_nx    = food_x;
      food_y_nx    = food_y;
      win_nx       = win;
      case (state_r)
         ST_INIT: begin
            tick_cnt_nx = '0;
            move_nx     = DIR_RIGHT;
            length_nx   = LEN_INIT;
            score_nx    = '0;
            food_x_nx   = rnd_x_s;
            food_y_nx   = rnd_y_s;
            win_nx      = 1'b0;
         end
         ST_WAIT: begin
            if (pause) begin
               tick_cnt_nx = tick_cnt_r;
            end else if (tick_cnt_r == TICK_LAST) begin
               tick_cnt_nx = '0;
               move_nx     = pending_r;
            end else begin
               tick_cnt_nx = tick_cnt_r + TW'(1);
            end
         end
         ST_CHECK: begin
            if (!self_col && head_hit_s) begin
               length_nx = len_inc_s;
               score_nx  = score + AB'(1);
               food_x_nx = rnd_x_s;
               food_y_nx = rnd_y_s;
               win_nx    = (len_inc_s == LEN_MAX);
            end else begin
               length_nx = length;
            end
         end
         default: begin
            tick_cnt_nx = tick_cnt_r;
         end
      endcase
   end

   // Direction filter: reversals are dropped, the last legal press wins.
   always_comb begin
      if (state_r == ST_INIT) begin
         pending_nx = DIR_RIGHT;
      end else if (btn_accept_s) begin
         pending_nx = btn_dir;
      end else begin
         pending_nx = pending_r;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt_r <= '0;
         pending_r  <= DIR_RIGHT;
         snake_rst  <= 1'b0;
         shift      <= 1'b0;
         move       <= DIR_RIGHT;
         length     <= LEN_INIT;
         food_x     <= FOOD_X0;
         food_y     <= FOOD_Y0;
         score      <= '0;
         game_over  <= 1'b0;
         win        <= 1'b0;
      end else begin
         tick_cnt_r <= tick_cnt_nx;
         pending_r  <= pending_nx;
         snake_rst  <= snake_rst_nx;
         shift      <= shift_nx;
         move       <= move_nx;
         length     <= length_nx;
         food_x     <= food_x_nx;
         food_y     <= food_y_nx;
         score      <= score_nx;
         game_over  <= game_over_nx;
         win        <= win_nx;
      end
   end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: a 32x32 instance for pacing, direction,
// food, pause, collision and reset, and a 4x4 instance for the full-board win.
module tb_snake_game_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] lfsr_m;

   logic        start1, pause1, btn_valid1, end_shift1, self_col1;
   logic [1:0]  btn_dir1;
   logic [10:0] last_head1;
   logic        snake_rst1, shift1, game_over1, win1;
   logic [1:0]  move1;
   logic [9:0]  length1, score1;
   logic [4:0]  food_x1, food_y1;

   logic        start2, end_shift2;
   logic [4:0]  last_head2;
   logic        snake_rst2, shift2, game_over2, win2;
   logic [1:0]  move2;
   logic [3:0]  length2, score2;
   logic [1:0]  food_x2, food_y2;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [1:0]  exp_move_q[$];
   logic [4:0]  efx, efy;
   logic [1:0]  efx2, efy2;
   int          cnt;

   snake_game_ctrl #(.H(32), .V(32), .TICK_DIV(8), .INIT_LEN(3), .LFSR_SEED(16'hACE1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .pause(pause1),
      .btn_valid(btn_valid1), .btn_dir(btn_dir1), .end_shift(end_shift1),
      .self_col(self_col1), .last_head(last_head1), .snake_rst(snake_rst1),
      .shift(shift1), .move(move1), .length(length1), .food_x(food_x1),
      .food_y(food_y1), .score(score1), .game_over(game_over1), .win(win1)
   );

   snake_game_ctrl #(.H(4), .V(4), .TICK_DIV(4), .INIT_LEN(14), .LFSR_SEED(16'hACE1)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .pause(1'b0),
      .btn_valid(1'b0), .btn_dir(2'd0), .end_shift(end_shift2),
      .self_col(1'b0), .last_head(last_head2), .snake_rst(snake_rst2),
      .shift(shift2), .move(move2), .length(length2), .food_x(food_x2),
      .food_y(food_y2), .score(score2), .game_over(game_over2), .win(win2)
   );

   always #5 clk = ~clk;

   // Reference food LFSR (taps 16,14,13,11), in step with both DUTs.
   always @(posedge clk or posedge reset) begin
      if (reset) lfsr_m <= 16'hACE1;
      else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Wait (bounded) for a shift pulse, then compare latency and move to the scoreboard.
   task automatic wait_shift(input int which, input int exp_n);
      int         n;
      bit         seen;
      logic [1:0] mv, em;
      n = 0; seen = 1'b0; mv = 2'd0; em = 2'd0;
      while (!seen && n < 300) begin
         @(negedge clk);
         n++;
         if ((which == 1) ? shift1 : shift2) begin
            seen = 1'b1;
            mv   = (which == 1) ? move1 : move2;
         end
      end
      chk("shift_seen", 32'(seen), 32'd1);
      if (exp_move_q.size() > 0) em = exp_move_q.pop_front();
      if (exp_n > 0) chk("shift_latency", 32'(n), 32'(exp_n));
      chk("move_at_shift", 32'(mv), 32'(em));
   endtask

   // Snake model: end_shift 20 cycles after shift, optional collision mid-scan.
   task automatic snake_resp(input bit on_food, input bit collide);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 9 && collide) self_col1 = 1'b1;
      end
      end_shift1 = 1'b1;
      last_head1 = on_food ? {efx, efy, 1'b1} : {efx ^ 5'd1, efy, 1'b1};
      @(negedge clk);
      end_shift1 = 1'b0;
   endtask

   task automatic pulse_btn(input logic [1:0] d);
      btn_valid1 = 1'b1;
      btn_dir1   = d;
      @(negedge clk);
      btn_valid1 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start1 = 1'b0; pause1 = 1'b0; btn_valid1 = 1'b0; btn_dir1 = 2'd0;
      end_shift1 = 1'b0; self_col1 = 1'b0; last_head1 = '0;
      start2 = 1'b0; end_shift2 = 1'b0; last_head2 = '0;
      repeat (2) @(negedge clk);
      chk("rst_snake_rst", 32'(snake_rst1), 32'd0);
      chk("rst_shift", 32'(shift1), 32'd0);
      chk("rst_move", 32'(move1), 32'd0);
      chk("rst_length", 32'(length1), 32'd3);
      chk("rst_food", 32'({food_x1, food_y1}), 32'({5'd8, 5'd8}));
      chk("rst_score_over_win", 32'({score1, game_over1, win1}), 32'd0);
      chk("rst2_length_food", 32'({length2, food_x2, food_y2}), 32'({4'd14, 2'd1, 2'd1}));
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Start: snake_rst the cycle after, first shift 8 cycles into WAIT_TICK.
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("start_snake_rst", 32'(snake_rst1), 32'd1);
      efx = lfsr_m[4:0];
      efy = lfsr_m[12:8];
      exp_move_q.push_back(2'd0);
      wait_shift(1, 9);
      chk("init_length", 32'(length1), 32'd3);
      chk("init_food", 32'({food_x1, food_y1}), 32'({efx, efy}));
      snake_resp(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("miss_length_score", 32'({length1, score1}), 32'({10'd3, 10'd0}));

      // Reversal (left while moving right) is ignored.
      pulse_btn(2'd2);
      exp_move_q.push_back(2'd0);
      wait_shift(1, 0);
      snake_resp(1'b0, 1'b0);
      repeat (3) @(negedge clk);

      // Up then down within one tick: the later legal press wins.
      pulse_btn(2'd1);
      pulse_btn(2'd3);
      exp_move_q.push_back(2'd3);
      wait_shift(1, 0);

      // Head lands on food: grow, score, new food from the LFSR.
      snake_resp(1'b1, 1'b0);
      repeat (2) @(negedge clk);
      efx = lfsr_m[4:0];
      efy = lfsr_m[12:8];
      @(negedge clk);
      chk("eat_length", 32'(length1), 32'd4);
      chk("eat_score", 32'(score1), 32'd1);
      chk("eat_food", 32'({food_x1, food_y1}), 32'({efx, efy}));
      chk("eat_not_over", 32'(game_over1), 32'd0);

      // Pause freezes the tick counter; shift follows after the remaining count.
      @(negedge clk);
      pause1 = 1'b1;
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (shift1) cnt++;
      end
      pause1 = 1'b0;
      chk("pause_no_shift", 32'(cnt), 32'd0);
      exp_move_q.push_back(2'd3);
      wait_shift(1, 7);

      // Self collision ends the game; no further shifts.
      snake_resp(1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("col_game_over", 32'(game_over1), 32'd1);
      chk("col_hold_length_win", 32'({length1, win1}), 32'({10'd4, 1'b0}));
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (shift1) cnt++;
      end
      chk("over_no_shift", 32'(cnt), 32'd0);

      // Restart from OVER.
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("restart_snake_rst", 32'(snake_rst1), 32'd1);
      self_col1 = 1'b0;
      efx = lfsr_m[4:0];
      efy = lfsr_m[12:8];
      @(negedge clk);
      chk("restart_score_over", 32'({score1, game_over1}), 32'd0);
      chk("restart_length_food", 32'({length1, food_x1, food_y1}), 32'({10'd3, efx, efy}));
      pulse_btn(2'd1);
      exp_move_q.push_back(2'd1);
      wait_shift(1, 0);

      // Reset during SCAN returns everything to reset values.
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_pulses", 32'({snake_rst1, shift1}), 32'd0);
      chk("midrst_move", 32'(move1), 32'd0);
      chk("midrst_length_food", 32'({length1, food_x1, food_y1}), 32'({10'd3, 5'd8, 5'd8}));
      chk("midrst_score_over_win", 32'({score1, game_over1, win1}), 32'd0);
      reset = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (shift1) cnt++;
      end
      chk("idle_no_shift", 32'(cnt), 32'd0);

      // 4x4 board: eating at length 14 fills the board.
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("win_snake_rst", 32'(snake_rst2), 32'd1);
      efx2 = lfsr_m[1:0];
      efy2 = lfsr_m[9:8];
      exp_move_q.push_back(2'd0);
      wait_shift(2, 5);
      chk("win_pre_length", 32'(length2), 32'd14);
      repeat (3) @(negedge clk);
      end_shift2 = 1'b1;
      last_head2 = {efx2, efy2, 1'b1};
      @(negedge clk);
      end_shift2 = 1'b0;
      repeat (2) @(negedge clk);
      efx2 = lfsr_m[1:0];
      efy2 = lfsr_m[9:8];
      @(negedge clk);
      chk("win_length", 32'(length2), 32'd15);
      chk("win_flags", 32'({win2, game_over2}), 32'({1'b1, 1'b1}));
      chk("win_score_food", 32'({score2, food_x2, food_y2}), 32'({4'd1, efx2, efy2}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
